// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the cpu/memory bus: widths and data FSM encoding.
package cpu_defs;

    localparam int DATA_WIDTH        = 36;
    localparam int INSTRUCTION_WIDTH = 18;
    localparam int ADDRESS_BUS_WIDTH = 14;

    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_WAIT_ENC   = 2'd1;
    localparam logic [1:0] ST_ACCESS_ENC = 2'd2;
    localparam logic [1:0] ST_ACK_ENC    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE_ENC,
        S_WAIT   = ST_WAIT_ENC,
        S_ACCESS = ST_ACCESS_ENC,
        S_ACK    = ST_ACK_ENC
    } dmem_state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Instruction-fetch and data-access bus between the cpu (master) and memory (slave).
// Signal names are from the memory's point of view.
interface data_mem_responder_if import cpu_defs::*; #(
    parameter int DW = DATA_WIDTH,
    parameter int IW = INSTRUCTION_WIDTH,
    parameter int AW = ADDRESS_BUS_WIDTH
);
    logic [AW-1:0] i_instr_addr;
    logic [IW-1:0] o_instruction;
    logic          i_mem_read;
    logic          i_mem_write;
    logic [AW-1:0] i_data_addr;
    logic [DW-1:0] i_data_write;
    logic [DW-1:0] o_data_mem;
    logic          o_busy;
    logic          o_ack;

    modport slave (
        input  i_instr_addr, i_mem_read, i_mem_write, i_data_addr, i_data_write,
        output o_instruction, o_data_mem, o_busy, o_ack
    );

    modport master (
        output i_instr_addr, i_mem_read, i_mem_write, i_data_addr, i_data_write,
        input  o_instruction, o_data_mem, o_busy, o_ack
    );
endinterface

// File: rtl/data_mem_responder_mem_array.sv
// Unified 18-bit word array: registered instruction read port plus a paired
// (even/odd word) data port used for 36-bit reads and writes.
// Contents are not reset; they are expected to be preloaded externally.
module mem_array_2r1w import cpu_defs::*; #(
    parameter int DW = DATA_WIDTH,
    parameter int IW = INSTRUCTION_WIDTH,
    parameter int AW = ADDRESS_BUS_WIDTH
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [AW-1:0] i_instr_addr,
    output logic [IW-1:0] o_instruction,
    input  logic          i_wr_en,
    input  logic [AW-2:0] i_pair,
    input  logic [DW-1:0] i_wr_data,
    output logic [DW-1:0] o_rd_data
);
    localparam int DEPTH = 2 ** AW;

    logic [IW-1:0] r_mem [0:DEPTH-1];
    logic [IW-1:0] r_instruction;
    logic [AW-1:0] w_lo_addr;
    logic [AW-1:0] w_hi_addr;

    // Even word holds the low half, odd word the high half; A+1 cannot wrap.
    assign w_lo_addr = {i_pair, 1'b0};
    assign w_hi_addr = {i_pair, 1'b1};

    // Both halves of a data write land on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[w_lo_addr] <= i_wr_data[IW-1:0];
            r_mem[w_hi_addr] <= i_wr_data[DW-1:IW];
        end
    end

    // Registered fetch; a same-edge write is not visible (returns old word).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_instruction <= '0;
        else          r_instruction <= r_mem[i_instr_addr];
    end

    assign o_instruction = r_instruction;
    assign o_rd_data     = {r_mem[w_hi_addr], r_mem[w_lo_addr]};
endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: 1-cycle instruction fetch and a wait-state data
// port with busy/ack handshake so the cpu can model slow data memory.
module data_mem_responder #(
    parameter int DATA_WIDTH        = cpu_defs::DATA_WIDTH,
    parameter int INSTRUCTION_WIDTH = cpu_defs::INSTRUCTION_WIDTH,
    parameter int ADDRESS_BUS_WIDTH = cpu_defs::ADDRESS_BUS_WIDTH,
    parameter int WAIT_STATES       = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    data_mem_responder_if.slave bus
);
    import cpu_defs::*;

    localparam int         PAIR_W      = ADDRESS_BUS_WIDTH - 1;
    localparam int         WAIT_LOAD_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0] WAIT_LOAD   = WAIT_LOAD_I[3:0];

    dmem_state_e             r_state,    w_state_nxt;
    logic [3:0]              r_wait_cnt, w_wait_cnt_nxt;
    logic [PAIR_W-1:0]       r_pair,     w_pair_nxt;
    logic                    r_is_write, w_is_write_nxt;
    logic [DATA_WIDTH-1:0]   r_wdata,    w_wdata_nxt;
    logic [DATA_WIDTH-1:0]   r_data_mem, w_data_mem_nxt;
    logic                    r_busy,     w_busy_nxt;
    logic                    r_ack,      w_ack_nxt;
    logic                    w_wr_en;
    logic [DATA_WIDTH-1:0]   w_rd_data;
    logic                    w_unused_addr_lsb;

    // Data accesses are 36-bit aligned; the word-select bit is ignored.
    assign w_unused_addr_lsb = bus.i_data_addr[0];

    mem_array_2r1w #(
        .DW (DATA_WIDTH),
        .IW (INSTRUCTION_WIDTH),
        .AW (ADDRESS_BUS_WIDTH)
    ) u_mem (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_instr_addr  (bus.i_instr_addr),
        .o_instruction (bus.o_instruction),
        .i_wr_en       (w_wr_en),
        .i_pair        (r_pair),
        .i_wr_data     (r_wdata),
        .o_rd_data     (w_rd_data)
    );

    // State and handshake registers; reset aborts any access in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_pair     <= '0;
            r_is_write <= 1'b0;
            r_wdata    <= '0;
            r_data_mem <= '0;
            r_busy     <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_pair     <= w_pair_nxt;
            r_is_write <= w_is_write_nxt;
            r_wdata    <= w_wdata_nxt;
            r_data_mem <= w_data_mem_nxt;
            r_busy     <= w_busy_nxt;
            r_ack      <= w_ack_nxt;
        end
    end

    // Next-state: accept in IDLE, burn wait states, do the access, pulse ack.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_pair_nxt     = r_pair;
        w_is_write_nxt = r_is_write;
        w_wdata_nxt    = r_wdata;
        w_data_mem_nxt = r_data_mem;
        w_busy_nxt     = r_busy;
        w_ack_nxt      = r_ack;
        w_wr_en        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_mem_write || bus.i_mem_read) begin
                    w_pair_nxt     = bus.i_data_addr[ADDRESS_BUS_WIDTH-1:1];
                    // Write wins when both requests are raised together.
                    w_is_write_nxt = bus.i_mem_write;
                    w_wdata_nxt    = bus.i_data_write;
                    w_busy_nxt     = 1'b1;
                    if (WAIT_STATES > 0) begin
                        w_state_nxt    = S_WAIT;
                        w_wait_cnt_nxt = WAIT_LOAD;
                    end else begin
                        w_state_nxt    = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == 4'd0) w_state_nxt = S_ACCESS;
                else                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
            end
            S_ACCESS: begin
                if (r_is_write) w_wr_en        = 1'b1;
                else            w_data_mem_nxt = w_rd_data;
                w_ack_nxt   = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_ACK;
            end
            S_ACK: begin
                w_ack_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.o_data_mem = r_data_mem;
    assign bus.o_busy     = r_busy;
    assign bus.o_ack      = r_ack;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one DUT with 2 wait states, one with 0.
module tb_data_mem_responder;

    logic clk;
    logic rst_n;
    int   checks;
    int   passed;

    data_mem_responder_if bus1 ();
    data_mem_responder_if bus0 ();

    data_mem_responder #(.WAIT_STATES(2)) u_dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus1)
    );

    data_mem_responder #(.WAIT_STATES(0)) u_dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_bus();
        bus1.i_mem_read   = 1'b0;
        bus1.i_mem_write  = 1'b0;
        bus1.i_data_addr  = '0;
        bus1.i_data_write = '0;
        bus0.i_mem_read   = 1'b0;
        bus0.i_mem_write  = 1'b0;
        bus0.i_data_addr  = '0;
        bus0.i_data_write = '0;
        bus0.i_instr_addr = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request, counts busy cycles and the edge index of ack
    // (0 = accept edge); drops the request in the ack cycle.
    task automatic run_access(input int sel, input logic rd, input logic wr,
                              input logic [13:0] addr, input logic [35:0] wdata,
                              output int ack_at, output int busy_n,
                              output logic [35:0] rdata);
        logic b, a;
        ack_at = -1;
        busy_n = 0;
        rdata  = 'x;
        if (sel == 1) begin
            bus1.i_mem_read = rd; bus1.i_mem_write = wr;
            bus1.i_data_addr = addr; bus1.i_data_write = wdata;
        end else begin
            bus0.i_mem_read = rd; bus0.i_mem_write = wr;
            bus0.i_data_addr = addr; bus0.i_data_write = wdata;
        end
        for (int i = 0; i < 20; i++) begin
            step();
            b = (sel == 1) ? bus1.o_busy : bus0.o_busy;
            a = (sel == 1) ? bus1.o_ack  : bus0.o_ack;
            if (b === 1'b1) busy_n++;
            if (a === 1'b1) begin
                ack_at = i;
                rdata  = (sel == 1) ? bus1.o_data_mem : bus0.o_data_mem;
                idle_bus();
                break;
            end
        end
        idle_bus();
        step();
    endtask

    task automatic fetch(input logic [13:0] a, output logic [17:0] q);
        bus1.i_instr_addr = a;
        step();
        q = bus1.o_instruction;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_bus();
        bus1.i_instr_addr = 14'd5;
        step();
        step();
        checks++; if (bus1.o_instruction !== 18'h0) $display("FAIL reset_instr got=%h exp=0", bus1.o_instruction); else passed++;
        checks++; if (bus1.o_data_mem !== 36'h0) $display("FAIL reset_data got=%h exp=0", bus1.o_data_mem); else passed++;
        checks++; if (bus1.o_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus1.o_busy); else passed++;
        checks++; if (bus1.o_ack !== 1'b0) $display("FAIL reset_ack got=%b exp=0", bus1.o_ack); else passed++;
        checks++; if (bus0.o_busy !== 1'b0 || bus0.o_ack !== 1'b0) $display("FAIL reset_dut0 got=%b%b exp=00", bus0.o_busy, bus0.o_ack); else passed++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fetch();
        int ack_at, busy_n;
        logic [35:0] rd;
        logic [17:0] q;
        // Preload mem[4]=11111, mem[5]=2A5A5 through the data port.
        run_access(1, 1'b0, 1'b1, 14'd4, {18'h2A5A5, 18'h11111}, ack_at, busy_n, rd);
        checks++; if (ack_at !== 3) $display("FAIL preload_ack got=%0d exp=3", ack_at); else passed++;
        fetch(14'd5, q);
        checks++; if (q !== 18'h2A5A5) $display("FAIL fetch5 got=%h exp=2a5a5", q); else passed++;
        fetch(14'd4, q);
        checks++; if (q !== 18'h11111) $display("FAIL fetch4 got=%h exp=11111", q); else passed++;
    endtask

    task automatic test_write_read();
        int ack_at, busy_n;
        logic [35:0] rd;
        logic [17:0] q;
        run_access(1, 1'b0, 1'b1, 14'd8, 36'h123456789, ack_at, busy_n, rd);
        checks++; if (ack_at !== 3) $display("FAIL wr_ack_lat got=%0d exp=3", ack_at); else passed++;
        checks++; if (busy_n !== 3) $display("FAIL wr_busy_cycles got=%0d exp=3", busy_n); else passed++;
        fetch(14'd8, q);
        checks++; if (q !== 18'h16789) $display("FAIL mem8 got=%h exp=16789", q); else passed++;
        fetch(14'd9, q);
        checks++; if (q !== 18'h048D1) $display("FAIL mem9 got=%h exp=048d1", q); else passed++;
        run_access(1, 1'b1, 1'b0, 14'd9, 36'h0, ack_at, busy_n, rd);
        checks++; if (ack_at !== 3) $display("FAIL rd_ack_lat got=%0d exp=3", ack_at); else passed++;
        checks++; if (busy_n !== 3) $display("FAIL rd_busy_cycles got=%0d exp=3", busy_n); else passed++;
        checks++; if (rd !== 36'h123456789) $display("FAIL rd_data got=%h exp=123456789", rd); else passed++;
    endtask

    task automatic test_zero_wait();
        int ack_at, busy_n;
        logic [35:0] rd;
        run_access(0, 1'b0, 1'b1, 14'd6, 36'hABCDE1234, ack_at, busy_n, rd);
        checks++; if (ack_at !== 1) $display("FAIL ws0_wr_ack got=%0d exp=1", ack_at); else passed++;
        checks++; if (busy_n !== 1) $display("FAIL ws0_wr_busy got=%0d exp=1", busy_n); else passed++;
        run_access(0, 1'b1, 1'b0, 14'd7, 36'h0, ack_at, busy_n, rd);
        checks++; if (ack_at !== 1) $display("FAIL ws0_rd_ack got=%0d exp=1", ack_at); else passed++;
        checks++; if (busy_n !== 1) $display("FAIL ws0_rd_busy got=%0d exp=1", busy_n); else passed++;
        checks++; if (rd !== 36'hABCDE1234) $display("FAIL ws0_rd_data got=%h exp=abcde1234", rd); else passed++;
    endtask

    task automatic test_rw_collision();
        int ack_at, busy_n;
        logic [35:0] rd;
        logic [17:0] q;
        run_access(1, 1'b1, 1'b1, 14'd4, 36'hFFFFFFFFF, ack_at, busy_n, rd);
        checks++; if (ack_at !== 3) $display("FAIL rw_ack got=%0d exp=3", ack_at); else passed++;
        checks++; if (rd !== 36'h123456789) $display("FAIL rw_data_at_ack got=%h exp=123456789", rd); else passed++;
        checks++; if (bus1.o_data_mem !== 36'h123456789) $display("FAIL rw_data_hold got=%h exp=123456789", bus1.o_data_mem); else passed++;
        fetch(14'd4, q);
        checks++; if (q !== 18'h3FFFF) $display("FAIL rw_mem4 got=%h exp=3ffff", q); else passed++;
        fetch(14'd5, q);
        checks++; if (q !== 18'h3FFFF) $display("FAIL rw_mem5 got=%h exp=3ffff", q); else passed++;
    endtask

    task automatic test_held_request();
        int first_ack, second_ack, busy_n;
        logic [35:0] rd2;
        first_ack = -1; second_ack = -1; busy_n = 0; rd2 = 'x;
        bus1.i_mem_read  = 1'b1;
        bus1.i_data_addr = 14'd8;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus1.o_busy === 1'b1) busy_n++;
            if (bus1.o_ack === 1'b1) begin
                if (first_ack < 0) first_ack = i;
                else begin
                    second_ack = i;
                    rd2 = bus1.o_data_mem;
                    idle_bus();
                    break;
                end
            end
        end
        idle_bus();
        step();
        checks++; if (first_ack !== 3) $display("FAIL held_first_ack got=%0d exp=3", first_ack); else passed++;
        checks++; if (second_ack !== 8) $display("FAIL held_second_ack got=%0d exp=8", second_ack); else passed++;
        checks++; if (busy_n !== 6) $display("FAIL held_busy_cycles got=%0d exp=6", busy_n); else passed++;
        checks++; if (rd2 !== 36'h123456789) $display("FAIL held_data got=%h exp=123456789", rd2); else passed++;
    endtask

    task automatic test_reset_mid_access();
        int ack_at, busy_n;
        logic [35:0] rd;
        logic [17:0] q;
        run_access(1, 1'b0, 1'b1, 14'd2, {18'h00002, 18'h00003}, ack_at, busy_n, rd);
        checks++; if (ack_at !== 3) $display("FAIL rst_prewrite_ack got=%0d exp=3", ack_at); else passed++;
        // Instruction register holds a nonzero word so the async clear shows.
        fetch(14'd5, q);
        checks++; if (q !== 18'h3FFFF) $display("FAIL rst_prefetch got=%h exp=3ffff", q); else passed++;
        bus1.i_mem_write  = 1'b1;
        bus1.i_data_addr  = 14'd2;
        bus1.i_data_write = 36'hFFFFFFFFF;
        step();
        checks++; if (bus1.o_busy !== 1'b1) $display("FAIL rst_accept_busy got=%b exp=1", bus1.o_busy); else passed++;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus1.o_busy !== 1'b0) $display("FAIL rst_async_busy got=%b exp=0", bus1.o_busy); else passed++;
        checks++; if (bus1.o_ack !== 1'b0) $display("FAIL rst_async_ack got=%b exp=0", bus1.o_ack); else passed++;
        checks++; if (bus1.o_instruction !== 18'h0) $display("FAIL rst_async_instr got=%h exp=0", bus1.o_instruction); else passed++;
        idle_bus();
        step();
        checks++; if (bus1.o_instruction !== 18'h0) $display("FAIL rst_hold_instr got=%h exp=0", bus1.o_instruction); else passed++;
        rst_n = 1'b1;
        fetch(14'd2, q);
        checks++; if (q !== 18'h00003) $display("FAIL rst_mem2 got=%h exp=00003", q); else passed++;
        fetch(14'd3, q);
        checks++; if (q !== 18'h00002) $display("FAIL rst_mem3 got=%h exp=00002", q); else passed++;
        run_access(1, 1'b1, 1'b0, 14'd3, 36'h0, ack_at, busy_n, rd);
        checks++; if (ack_at !== 3) $display("FAIL rst_after_ack got=%0d exp=3", ack_at); else passed++;
        checks++; if (rd !== {18'h00002, 18'h00003}) $display("FAIL rst_after_data got=%h exp=000080003", rd); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst_n  = 1'b0;
        idle_bus();
        bus1.i_instr_addr = '0;
        test_reset();
        test_fetch();
        test_write_read();
        test_zero_wait();
        test_rw_collision();
        test_held_request();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
